// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with valid/ready handshake and a one-entry skid buffer.
// in_ready is a flop derived from next state, so the memory stage never sees a combinational path back to execute.
module exe_mem_skid_reg #(
  parameter int WORD_W = 32,
  parameter int CTRL_W = 3,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [WORD_W-1:0] in_imm,
  input  logic [WORD_W-1:0] in_alu,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_imm,
  output logic [WORD_W-1:0] out_alu,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEST_W-1:0] out_dest,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] alu;
    logic [CTRL_W-1:0] ctrl;
    logic [DEST_W-1:0] dest;
  } entry_t;

  // State is just {main valid, skid valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;

  entry_t main_q, skid_q, main_d, skid_d, in_e;
  logic   main_vld, skid_vld, main_vld_d, skid_vld_d, in_ready_q;
  logic   accept, fire;
  state_t st;

  assign in_e   = '{pc: in_pc, imm: in_imm, alu: in_alu, ctrl: in_ctrl, dest: in_dest};
  assign accept = in_valid & in_ready_q;
  assign fire   = main_vld & out_ready;
  assign st     = state_t'({main_vld, skid_vld});

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld;
    skid_vld_d = skid_vld;
    if (flush) begin
      main_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
      main_d.ctrl = '0;
      skid_d.ctrl = '0;
    end else begin
      case (st)
        EMPTY: if (accept) begin
          main_d     = in_e;
          main_vld_d = 1'b1;
        end
        ONE: begin
          if (accept && fire) main_d = in_e;
          else if (accept) begin
            skid_d     = in_e;
            skid_vld_d = 1'b1;
          end else if (fire) begin
            main_vld_d  = 1'b0;
            main_d.ctrl = '0;
          end
        end
        FULL: if (fire) begin
          main_d      = skid_q;
          skid_vld_d  = 1'b0;
          skid_d.ctrl = '0;
        end
        default: begin
          skid_vld_d  = 1'b0;
          skid_d.ctrl = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      in_ready_q <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld   <= main_vld_d;
      skid_vld   <= skid_vld_d;
      in_ready_q <= ~skid_vld_d;
      if (main_vld && !out_ready && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld;
  assign out_pc    = main_q.pc;
  assign out_imm   = main_q.imm;
  assign out_alu   = main_q.alu;
  assign out_ctrl  = main_q.ctrl;
  assign out_dest  = main_q.dest;
endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Table-driven bench for exe_mem_skid_reg with an in-order scoreboard of accepted entries.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_exe_mem_skid_reg;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_imm, in_alu;
  logic [2:0]  in_ctrl;
  logic [4:0]  in_dest;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm, out_alu;
  logic [2:0]  out_ctrl;
  logic [4:0]  out_dest;
  logic [15:0] stall_cnt;
  logic        in_ready2, out_valid2;
  logic [31:0] out_pc2, out_imm2, out_alu2;
  logic [2:0]  out_ctrl2;
  logic [4:0]  out_dest2;
  logic [1:0]  stall_cnt2;

  always #5 clk = ~clk;

  exe_mem_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_alu(in_alu), .in_ctrl(in_ctrl), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_alu(out_alu), .out_ctrl(out_ctrl), .out_dest(out_dest), .stall_cnt(stall_cnt));

  exe_mem_skid_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_pc(in_pc), .in_imm(in_imm), .in_alu(in_alu), .in_ctrl(in_ctrl), .in_dest(in_dest),
    .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc2), .out_imm(out_imm2),
    .out_alu(out_alu2), .out_ctrl(out_ctrl2), .out_dest(out_dest2), .stall_cnt(stall_cnt2));

  // One row = inputs for a cycle plus the outputs expected just before that cycle's edge.
  typedef struct {
    logic        rst, iv;
    logic [31:0] pc;
    logic [2:0]  ctrl;
    logic        ordy, fl;
    logic        e_ov, e_ir;
    logic [2:0]  e_ctrl;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct { logic [31:0] pc; logic [2:0] ctrl; } sb_t;

  sb_t  sb[$];
  vec_t tbl[18];
  int   checks = 0, failures = 0;

  function automatic logic [31:0] imm_of(input logic [31:0] pc); return pc ^ 32'hA5A5_0000; endfunction
  function automatic logic [31:0] alu_of(input logic [31:0] pc); return pc + 32'd1000; endfunction
  function automatic logic [4:0]  dest_of(input logic [31:0] pc); return pc[6:2]; endfunction

  function automatic vec_t mk(input logic r, iv, input logic [31:0] pc, input logic [2:0] c,
                              input logic ordy, fl, e_ov, e_ir, input logic [2:0] e_c,
                              input logic [31:0] e_pc, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.pc = pc; v.ctrl = c; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_ctrl = e_c; v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input vec_t v);
    sb_t e;
    chk("out_valid", {31'd0, out_valid}, {31'd0, v.e_ov});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, v.e_ir});
    chk("out_ctrl",  {29'd0, out_ctrl},  {29'd0, v.e_ctrl});
    chk("out_pc",    out_pc, v.e_pc);
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, v.e_cnt});
    if (v.rst) sb.delete();
    else begin
      if (v.e_ov && v.ordy) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("sb_pc",   out_pc, e.pc);
          chk("sb_alu",  out_alu, alu_of(e.pc));
          chk("sb_imm",  out_imm, imm_of(e.pc));
          chk("sb_dest", {27'd0, out_dest}, {27'd0, dest_of(e.pc)});
          chk("sb_ctrl", {29'd0, out_ctrl}, {29'd0, e.ctrl});
        end
      end
      if (v.fl) sb.delete();
      else if (v.iv && v.e_ir) sb.push_back('{pc: v.pc, ctrl: v.ctrl});
    end
    rst = v.rst; in_valid = v.iv; in_pc = v.pc; in_imm = imm_of(v.pc); in_alu = alu_of(v.pc);
    in_dest = dest_of(v.pc); in_ctrl = v.ctrl; out_ready = v.ordy; flush = v.fl;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_imm = '0; in_alu = '0; in_ctrl = '0; in_dest = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_imm",  out_imm, 32'd0);
    chk("rst_alu",  out_alu, 32'd0);
    chk("rst_dest", {27'd0, out_dest}, 32'd0);

    //             rst iv  pc        ctrl    ordy fl ov ir e_ctrl  e_pc      cnt
    tbl[0]  = mk(0, 1, 32'h100, 3'b001, 1, 0, 0, 1, 3'b000, 32'h000, 0);
    tbl[1]  = mk(0, 1, 32'h104, 3'b010, 1, 0, 1, 1, 3'b001, 32'h100, 0);
    tbl[2]  = mk(0, 1, 32'h108, 3'b100, 1, 0, 1, 1, 3'b010, 32'h104, 0);
    tbl[3]  = mk(0, 0, 32'h000, 3'b000, 1, 0, 1, 1, 3'b100, 32'h108, 0);
    tbl[4]  = mk(0, 1, 32'h200, 3'b011, 0, 0, 0, 1, 3'b000, 32'h108, 0);
    tbl[5]  = mk(0, 1, 32'h204, 3'b110, 0, 0, 1, 1, 3'b011, 32'h200, 0);
    tbl[6]  = mk(0, 1, 32'h208, 3'b111, 0, 0, 1, 0, 3'b011, 32'h200, 1);
    tbl[7]  = mk(0, 0, 32'h000, 3'b000, 1, 0, 1, 0, 3'b011, 32'h200, 2);
    tbl[8]  = mk(0, 0, 32'h000, 3'b000, 1, 0, 1, 1, 3'b110, 32'h204, 2);
    tbl[9]  = mk(0, 0, 32'h000, 3'b000, 1, 0, 0, 1, 3'b000, 32'h204, 2);
    tbl[10] = mk(0, 1, 32'h300, 3'b101, 0, 0, 0, 1, 3'b000, 32'h204, 2);
    for (int i = 0; i < 5; i++)
      tbl[11+i] = mk(0, 0, 32'h000, 3'b000, 0, 0, 1, 1, 3'b101, 32'h300, 16'(2+i));
    tbl[16] = mk(0, 0, 32'h000, 3'b000, 1, 0, 1, 1, 3'b101, 32'h300, 7);
    tbl[17] = mk(0, 0, 32'h000, 3'b000, 1, 0, 0, 1, 3'b000, 32'h300, 7);
    for (int i = 0; i < 18; i++) cyc(tbl[i]);
    chk("gate_alu_kept", out_alu, alu_of(32'h300));

    // Flush while FULL with a new entry offered: nothing held may ever reach the output.
    cyc(mk(0, 1, 32'h400, 3'b001, 0, 0, 0, 1, 3'b000, 32'h300, 7));
    cyc(mk(0, 1, 32'h404, 3'b010, 0, 0, 1, 1, 3'b001, 32'h400, 7));
    cyc(mk(0, 1, 32'h408, 3'b100, 0, 1, 1, 0, 3'b001, 32'h400, 8));
    for (int i = 0; i < 3; i++)
      cyc(mk(0, 0, 32'h000, 3'b000, 1, 0, 0, 1, 3'b000, 32'h400, 9));

    // Reset while FULL drops both entries.
    cyc(mk(0, 1, 32'h500, 3'b011, 0, 0, 0, 1, 3'b000, 32'h400, 9));
    cyc(mk(0, 1, 32'h504, 3'b101, 0, 0, 1, 1, 3'b011, 32'h500, 9));
    cyc(mk(1, 0, 32'h000, 3'b000, 1, 0, 1, 0, 3'b011, 32'h500, 10));
    chk("rst2_imm",  out_imm, 32'd0);
    chk("rst2_alu",  out_alu, 32'd0);
    chk("rst2_dest", {27'd0, out_dest}, 32'd0);
    chk("rst2_cnt2", {30'd0, stall_cnt2}, 32'd0);
    for (int i = 0; i < 2; i++)
      cyc(mk(0, 0, 32'h000, 3'b000, 1, 0, 0, 1, 3'b000, 32'h000, 0));

    // Six stalled cycles: wide counter reads 6, 2-bit counter pins at 3.
    cyc(mk(0, 1, 32'h600, 3'b111, 0, 0, 0, 1, 3'b000, 32'h000, 0));
    for (int i = 0; i < 6; i++)
      cyc(mk(0, 0, 32'h000, 3'b000, 0, 0, 1, 1, 3'b111, 32'h600, 16'(i)));
    chk("sat_cnt2", {30'd0, stall_cnt2}, 32'd3);
    cyc(mk(0, 0, 32'h000, 3'b000, 1, 0, 1, 1, 3'b111, 32'h600, 6));
    cyc(mk(0, 0, 32'h000, 3'b000, 1, 0, 0, 1, 3'b000, 32'h600, 6));
    chk("drain_alu_kept", out_alu, alu_of(32'h600));
    chk("sat_cnt2_hold", {30'd0, stall_cnt2}, 32'd3);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
